// File: rtl/raster_work_issuer.sv
// Raster-order work item producer: walks an inclusive x/y region and offers one
// {last, y, x} item per coordinate on a valid / registered-acknowledge handshake.
module raster_work_issuer #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 8,
    localparam int STATE_VARS_WIDTH = 1 + Y_WIDTH + X_WIDTH,
    localparam int COUNT_WIDTH = X_WIDTH + Y_WIDTH + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [X_WIDTH-1:0]          x_min,
    input  logic [X_WIDTH-1:0]          x_max,
    input  logic [Y_WIDTH-1:0]          y_min,
    input  logic [Y_WIDTH-1:0]          y_max,
    output logic                        busy,
    output logic                        done,
    output logic [COUNT_WIDTH-1:0]      item_count,
    output logic [STATE_VARS_WIDTH-1:0] state_vars_next,
    output logic                        state_vars_next_valid,
    input  logic                        state_accepted
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t state_q, state_d;

    logic [X_WIDTH-1:0] x_min_r, x_max_r, cur_x;
    logic [Y_WIDTH-1:0] y_max_r, cur_y;

    logic bounds_ok, is_last, idle_start, issue_ack;

    assign bounds_ok  = (x_min <= x_max) && (y_min <= y_max);
    assign is_last    = (cur_x == x_max_r) && (cur_y == y_max_r);
    assign idle_start = (state_q == IDLE) && start;
    assign issue_ack  = (state_q == ISSUE) && state_accepted;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && bounds_ok) state_d = ISSUE;
            ISSUE:   if (state_accepted && is_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control: completion pulse and accepted-item counter
    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            item_count <= '0;
        end else begin
            done <= 1'b0;
            if (idle_start) begin
                item_count <= '0;
                done       <= ~bounds_ok;
            end else if (issue_ack) begin
                item_count <= item_count + COUNT_WIDTH'(1);
                done       <= is_last;
            end
        end
    end

    // Datapath: latched bounds and raster cursor; only meaningful while busy
    always_ff @(posedge clk) begin
        if (idle_start && bounds_ok) begin
            x_min_r <= x_min;
            x_max_r <= x_max;
            y_max_r <= y_max;
            cur_x   <= x_min;
            cur_y   <= y_min;
        end else if (issue_ack && !is_last) begin
            if (cur_x == x_max_r) begin
                cur_x <= x_min_r;
                cur_y <= cur_y + Y_WIDTH'(1);
            end else begin
                cur_x <= cur_x + X_WIDTH'(1);
            end
        end
    end

    // Valid is masked during the acknowledge cycle so an item is never taken twice
    assign busy                  = (state_q == ISSUE);
    assign state_vars_next_valid = busy & ~state_accepted;
    assign state_vars_next       = busy ? {is_last, cur_y, cur_x} : '0;

endmodule

// File: tb/tb_raster_work_issuer.sv
// Directed bench for raster_work_issuer: region walks, single pixel, inverted
// bounds, backpressure, ignored start/stray acknowledge, and mid-region reset.
module tb_raster_work_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  x_min, x_max, y_min, y_max;
    logic        busy, done;
    logic [16:0] item_count;
    logic [16:0] state_vars_next;
    logic        state_vars_next_valid;
    logic        state_accepted;

    int n_checks = 0;
    int n_fails  = 0;

    raster_work_issuer #(.X_WIDTH(8), .Y_WIDTH(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .x_min                 (x_min),
        .x_max                 (x_max),
        .y_min                 (y_min),
        .y_max                 (y_max),
        .busy                  (busy),
        .done                  (done),
        .item_count            (item_count),
        .state_vars_next       (state_vars_next),
        .state_vars_next_valid (state_vars_next_valid),
        .state_accepted        (state_accepted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [16:0] item(input logic last, input logic [7:0] y, input logic [7:0] x);
        return {last, y, x};
    endfunction

    task automatic start_region(input logic [7:0] xa, input logic [7:0] xb,
                                input logic [7:0] ya, input logic [7:0] yb);
        x_min = xa; x_max = xb; y_min = ya; y_max = yb;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    // Consumer pushes at the next edge, then holds its registered acknowledge for one cycle
    task automatic accept_item(input string tag, input logic [16:0] exp);
        chk({tag, "_valid"}, state_vars_next_valid, 1);
        chk({tag, "_item"}, state_vars_next, exp);
        chk({tag, "_done_low"}, done, 0);
        tick();
        state_accepted = 1'b1;
        #1;
        chk({tag, "_valid_masked"}, state_vars_next_valid, 0);
        tick();
        state_accepted = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; state_accepted = 1'b0;
        x_min = 0; x_max = 0; y_min = 0; y_max = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", item_count, 0);
        chk("rst_item", state_vars_next, 0);
        chk("rst_valid", state_vars_next_valid, 0);
        rst = 1'b0;
        tick();

        // Region x 3..4, y 7..8 with immediate acknowledges
        start_region(8'd3, 8'd4, 8'd7, 8'd8);
        chk("r1_busy", busy, 1);
        accept_item("r1_i0", item(1'b0, 8'd7, 8'd3));
        accept_item("r1_i1", item(1'b0, 8'd7, 8'd4));
        accept_item("r1_i2", item(1'b0, 8'd8, 8'd3));
        accept_item("r1_i3", item(1'b1, 8'd8, 8'd4));
        chk("r1_done", done, 1);
        chk("r1_busy_low", busy, 0);
        chk("r1_count", item_count, 4);
        tick();
        chk("r1_done_pulse", done, 0);

        // Single pixel
        start_region(8'd5, 8'd5, 8'd5, 8'd5);
        accept_item("sp", item(1'b1, 8'd5, 8'd5));
        chk("sp_done", done, 1);
        chk("sp_count", item_count, 1);
        tick();
        chk("sp_done_pulse", done, 0);

        // Inverted x bounds
        start_region(8'd9, 8'd2, 8'd0, 8'd3);
        chk("inv_done", done, 1);
        chk("inv_busy", busy, 0);
        chk("inv_valid", state_vars_next_valid, 0);
        chk("inv_count", item_count, 0);
        tick();
        chk("inv_done_pulse", done, 0);
        chk("inv_valid2", state_vars_next_valid, 0);
        chk("inv_busy2", busy, 0);

        // Backpressure: first item held for six cycles
        start_region(8'd0, 8'd1, 8'd0, 8'd0);
        for (int i = 0; i < 6; i++) begin
            chk("bp_hold_valid", state_vars_next_valid, 1);
            chk("bp_hold_item", state_vars_next, item(1'b0, 8'd0, 8'd0));
            tick();
        end
        accept_item("bp_i0", item(1'b0, 8'd0, 8'd0));
        accept_item("bp_i1", item(1'b1, 8'd0, 8'd1));
        chk("bp_done", done, 1);
        chk("bp_count", item_count, 2);
        tick();

        // Start with new bounds while issuing is ignored
        start_region(8'd1, 8'd2, 8'd2, 8'd2);
        x_min = 8'd10; x_max = 8'd12; y_min = 8'd0; y_max = 8'd0;
        start = 1'b1;
        accept_item("ig_i0", item(1'b0, 8'd2, 8'd1));
        accept_item("ig_i1", item(1'b1, 8'd2, 8'd2));
        start = 1'b0;
        chk("ig_done", done, 1);
        chk("ig_count", item_count, 2);
        tick();
        // Stray acknowledge while idle
        state_accepted = 1'b1;
        #1;
        chk("stray_valid", state_vars_next_valid, 0);
        tick();
        state_accepted = 1'b0;
        #1;
        chk("stray_done", done, 0);
        chk("stray_count", item_count, 2);
        chk("stray_busy", busy, 0);
        tick();
        chk("stray_done2", done, 0);

        // Reset after two of four items, then a fresh full run
        start_region(8'd0, 8'd1, 8'd0, 8'd1);
        accept_item("rs_i0", item(1'b0, 8'd0, 8'd0));
        accept_item("rs_i1", item(1'b0, 8'd0, 8'd1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_done", done, 0);
        chk("rs_count", item_count, 0);
        chk("rs_item", state_vars_next, 0);
        chk("rs_valid", state_vars_next_valid, 0);
        tick();
        chk("rs_done2", done, 0);
        start_region(8'd0, 8'd1, 8'd0, 8'd1);
        accept_item("rs2_i0", item(1'b0, 8'd0, 8'd0));
        accept_item("rs2_i1", item(1'b0, 8'd0, 8'd1));
        accept_item("rs2_i2", item(1'b0, 8'd1, 8'd0));
        accept_item("rs2_i3", item(1'b1, 8'd1, 8'd1));
        chk("rs2_done", done, 1);
        chk("rs2_count", item_count, 4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
